tinyalu_cmd_issuer: RTL and testbench

TINYALU_CMD_ISSUER -- requirements
Module: tinyalu_cmd_issuer

---
 rtl/tinyalu_pkg.sv | 34 +++
 rtl/tinyalu_cmd_fifo.sv | 59 +++++
 rtl/tinyalu_cmd_issuer.sv | 175 +++++++++++++++++
 tb/tb_tinyalu_cmd_issuer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU command issuer: operation codes, FSM states
// and the queued command payload.
package tinyalu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CMD_W  = OP_W + 2 * DATA_W;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [2:0] {
        st_idle,
        st_issue,
        st_wait_done,
        st_alu_rst,
        st_resp
    } issuer_state_t;

    // FIFO entry layout {op, b, a}
    typedef struct packed {
        operation_t        op;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } cmd_t;

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Command FIFO for the TinyALU issuer; power-of-two depth, registered
// full/empty flags, synchronous active-low reset.
module tinyalu_cmd_fifo
    import tinyalu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // simultaneous push and pop leaves occupancy unchanged
    always_comb begin
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tinyalu_cmd_issuer.sv
// Queues ALU commands and sequences them onto a TinyALU, returning one response
// per command. Optional WAIT_DONE timeout: define TINYALU_ISSUER_TIMEOUT_EN.
module tinyalu_cmd_issuer
    import tinyalu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        alu_rst_n,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        busy
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("tinyalu_cmd_issuer: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES > 0");
    end

    issuer_state_t state;
    cmd_t          push_cmd;
    cmd_t          head;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          rst_done;
    logic          alu_rst_pulse;

    always_comb begin
        push_cmd    = '0;
        push_cmd.op = operation_t'(cmd_op);
        push_cmd.b  = cmd_b;
        push_cmd.a  = cmd_a;
    end

    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state == st_idle) && !fifo_empty;
    // held low through reset and for one cycle after release
    assign cmd_ready = rst_done && !fifo_full;
    assign busy      = (state != st_idle) || !fifo_empty;
    assign alu_rst_n = reset_n && !alu_rst_pulse;

    tinyalu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef TINYALU_ISSUER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= st_idle;
            rst_done      <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= no_op;
            alu_start     <= 1'b0;
            alu_rst_pulse <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_op        <= no_op;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
            tmo_cnt       <= '0;
            rsp_err       <= 1'b0;
`endif
        end else begin
            rst_done <= 1'b1;
            case (state)
                st_idle: begin
                    if (!fifo_empty) begin
                        alu_a  <= head.a;
                        alu_b  <= head.b;
                        alu_op <= head.op;
                        if (head.op == rst_op) begin
                            alu_rst_pulse <= 1'b1;
                            state         <= st_alu_rst;
                        end else begin
                            alu_start <= 1'b1;
                            state     <= st_issue;
                        end
                    end
                end
                st_issue: begin
                    if (alu_op == no_op) begin
                        alu_start  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_result <= '0;
                        rsp_op     <= alu_op;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
                        rsp_err    <= 1'b0;
`endif
                        state      <= st_resp;
                    end else begin
`ifdef TINYALU_ISSUER_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                        state      <= st_wait_done;
                    end
                end
                st_wait_done: begin
                    if (alu_done) begin
                        alu_start  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_result <= alu_result;
                        rsp_op     <= alu_op;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
                        rsp_err    <= 1'b0;
`endif
                        state      <= st_resp;
                    end
`ifdef TINYALU_ISSUER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        alu_start  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_result <= 16'hFFFF;
                        rsp_op     <= alu_op;
                        rsp_err    <= 1'b1;
                        state      <= st_resp;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                st_alu_rst: begin
                    alu_rst_pulse <= 1'b0;
                    rsp_valid     <= 1'b1;
                    rsp_result    <= '0;
                    rsp_op        <= alu_op;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
                    rsp_err       <= 1'b0;
`endif
                    state         <= st_resp;
                end
                st_resp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= st_idle;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_cmd_issuer.sv
// Directed testbench for tinyalu_cmd_issuer; the timeout scenario is built
// only when TINYALU_ISSUER_TIMEOUT_EN is defined.
module tb_tinyalu_cmd_issuer;
    import tinyalu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        alu_rst_n;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        busy;

    int checks;
    int failures;

    tinyalu_cmd_issuer #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_rst_n  (alu_rst_n),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({cmd_ready, alu_start, rsp_valid, rsp_err, busy, alu_rst_n} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {cmd_ready, alu_start, rsp_valid, rsp_err, busy, alu_rst_n});
        end
        checks++;
        if ({alu_a, alu_b, alu_op, rsp_result, rsp_op} !== 38'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {alu_a, alu_b, alu_op, rsp_result, rsp_op});
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, alu_rst_n, busy} !== 3'b110) begin
            failures++;
            $display("FAIL reset_release got=%b exp=110", {cmd_ready, alu_rst_n, busy});
        end
    endtask

    // add 5+7, single-cycle done; checks minimum latency pipeline
    task automatic test_add();
        drive_cmd(add_op, 8'h05, 8'h07);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({alu_start, busy} !== 2'b01) begin
            failures++;
            $display("FAIL add_accept got=%b exp=01", {alu_start, busy});
        end
        tick();
        checks++;
        if ({alu_a, alu_b, alu_op, alu_start} !== {8'h05, 8'h07, 3'b001, 1'b1}) begin
            failures++;
            $display("FAIL add_pop got=%h exp=%h", {alu_a, alu_b, alu_op, alu_start}, {8'h05, 8'h07, 3'b001, 1'b1});
        end
        tick();
        alu_done   = 1'b1;
        alu_result = 16'h000C;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_early_rsp got=%b exp=0", rsp_valid);
        end
        tick();
        alu_done   = 1'b0;
        alu_result = 16'h0000;
        checks++;
        if ({rsp_valid, rsp_result, rsp_op, rsp_err, alu_start} !== {1'b1, 16'h000C, 3'b001, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_rsp got=%h exp=%h", {rsp_valid, rsp_result, rsp_op, rsp_err, alu_start},
                     {1'b1, 16'h000C, 3'b001, 1'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL add_handshake got=%b exp=00", {rsp_valid, busy});
        end
    endtask

    // blocker stalls the ALU; FIFO fills with 4, 5th waits for the first pop
    task automatic test_back_to_back();
        int cyc;
        logic [7:0] exp_a;
        drive_cmd(add_op, 8'h01, 8'h01);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready_%0d got=%b exp=1", i, cmd_ready);
            end
            drive_cmd(xor_op, 8'h10 + 8'(i), 8'h03);
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full got=%b exp=0", cmd_ready);
        end
        drive_cmd(xor_op, 8'h14, 8'h03);
        tick();
        tick();
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_still_full got=%b exp=0", cmd_ready);
        end
        alu_done   = 1'b1;
        alu_result = 16'h0002;
        tick();
        alu_done   = 1'b0;
        checks++;
        if ({rsp_valid, rsp_result} !== {1'b1, 16'h0002}) begin
            failures++;
            $display("FAIL b2b_blocker_rsp got=%h exp=%h", {rsp_valid, rsp_result}, {1'b1, 16'h0002});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_before_pop got=%b exp=0", cmd_ready);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_after_pop got=%b exp=1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_fifth_accept got=%b exp=0", cmd_ready);
        end
        for (int k = 0; k < 5; k++) begin
            exp_a = 8'h10 + 8'(k);
            cyc = 0;
            while (alu_start !== 1'b1 && cyc < 20) begin
                tick();
                cyc++;
            end
            checks++;
            if (alu_a !== exp_a || alu_start !== 1'b1) begin
                failures++;
                $display("FAIL b2b_order_%0d got_a=%h start=%b exp_a=%h", k, alu_a, alu_start, exp_a);
            end
            tick();
            alu_done   = 1'b1;
            alu_result = 16'(exp_a ^ 8'h03);
            tick();
            alu_done   = 1'b0;
            checks++;
            if ({rsp_valid, rsp_result, rsp_op} !== {1'b1, 16'(exp_a ^ 8'h03), 3'b011}) begin
                failures++;
                $display("FAIL b2b_rsp_%0d got=%h exp=%h", k, {rsp_valid, rsp_result, rsp_op},
                         {1'b1, 16'(exp_a ^ 8'h03), 3'b011});
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drained got=%b exp=0", busy);
        end
    endtask

    task automatic test_noop_rst();
        drive_cmd(no_op, 8'h03, 8'h04);
        tick();
        drive_cmd(rst_op, 8'h00, 8'h00);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({alu_start, alu_op} !== {1'b1, 3'b000}) begin
            failures++;
            $display("FAIL noop_issue got=%b exp=1000", {alu_start, alu_op});
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_result, rsp_op, alu_start} !== {1'b1, 16'h0000, 3'b000, 1'b0}) begin
            failures++;
            $display("FAIL noop_rsp got=%h exp=%h", {rsp_valid, rsp_result, rsp_op, alu_start}, {1'b1, 20'h0});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, alu_rst_n} !== 2'b01) begin
            failures++;
            $display("FAIL rst_before_pulse got=%b exp=01", {rsp_valid, alu_rst_n});
        end
        tick();
        checks++;
        if ({alu_rst_n, alu_start, alu_op} !== {1'b0, 1'b0, 3'b111}) begin
            failures++;
            $display("FAIL rst_pulse got=%b exp=00111", {alu_rst_n, alu_start, alu_op});
        end
        tick();
        checks++;
        if ({alu_rst_n, alu_start, rsp_valid, rsp_result, rsp_op} !== {1'b1, 1'b0, 1'b1, 16'h0000, 3'b111}) begin
            failures++;
            $display("FAIL rst_rsp got=%h exp=%h", {alu_rst_n, alu_start, rsp_valid, rsp_result, rsp_op},
                     {1'b1, 1'b0, 1'b1, 16'h0000, 3'b111});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // FF*FF held under back-pressure; stray alu_done during ISSUE is ignored
    task automatic test_backpressure();
        drive_cmd(mul_op, 8'hFF, 8'hFF);
        tick();
        drive_cmd(add_op, 8'h01, 8'h02);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({alu_start, alu_op} !== {1'b1, 3'b100}) begin
            failures++;
            $display("FAIL mul_issue got=%b exp=1100", {alu_start, alu_op});
        end
        alu_done   = 1'b1;
        alu_result = 16'hDEAD;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mul_done_in_issue got=%b exp=0", rsp_valid);
        end
        alu_result = 16'hFE01;
        tick();
        alu_done   = 1'b0;
        alu_result = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, rsp_result, rsp_op, alu_start, alu_op} !== {1'b1, 16'hFE01, 3'b100, 1'b0, 3'b100}) begin
                failures++;
                $display("FAIL mul_hold_%0d got=%h exp=%h", i, {rsp_valid, rsp_result, rsp_op, alu_start, alu_op},
                         {1'b1, 16'hFE01, 3'b100, 1'b0, 3'b100});
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, alu_start} !== 2'b00) begin
            failures++;
            $display("FAIL mul_handshake got=%b exp=00", {rsp_valid, alu_start});
        end
        tick();
        checks++;
        if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, 3'b001, 8'h01, 8'h02}) begin
            failures++;
            $display("FAIL mul_next_issue got=%h exp=%h", {alu_start, alu_op, alu_a, alu_b}, {1'b1, 3'b001, 8'h01, 8'h02});
        end
        tick();
        alu_done   = 1'b1;
        alu_result = 16'h0003;
        tick();
        alu_done   = 1'b0;
        checks++;
        if ({rsp_valid, rsp_result, rsp_op} !== {1'b1, 16'h0003, 3'b001}) begin
            failures++;
            $display("FAIL mul_next_rsp got=%h exp=%h", {rsp_valid, rsp_result, rsp_op}, {1'b1, 16'h0003, 3'b001});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

`ifdef TINYALU_ISSUER_TIMEOUT_EN
    task automatic test_timeout();
        drive_cmd(and_op, 8'h0F, 8'hF0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 31; i++) tick();
        checks++;
        if ({rsp_valid, alu_start} !== 2'b01) begin
            failures++;
            $display("FAIL tmo_early got=%b exp=01", {rsp_valid, alu_start});
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_result, rsp_op, alu_start} !== {1'b1, 1'b1, 16'hFFFF, 3'b010, 1'b0}) begin
            failures++;
            $display("FAIL tmo_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_result, rsp_op, alu_start},
                     {1'b1, 1'b1, 16'hFFFF, 3'b010, 1'b0});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask
`endif

    // reset while stalled in WAIT_DONE with two commands queued
    task automatic test_reset_mid();
        drive_cmd(add_op, 8'h11, 8'h22);
        tick();
        drive_cmd(and_op, 8'h33, 8'h44);
        tick();
        drive_cmd(xor_op, 8'h55, 8'h66);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({busy, alu_start} !== 2'b11) begin
            failures++;
            $display("FAIL mid_pre_reset got=%b exp=11", {busy, alu_start});
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if ({busy, alu_start, rsp_valid, cmd_ready, alu_rst_n} !== 5'b0) begin
            failures++;
            $display("FAIL mid_in_reset got=%b exp=00000", {busy, alu_start, rsp_valid, cmd_ready, alu_rst_n});
        end
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy, alu_start, rsp_valid, cmd_ready} !== 4'b0001) begin
                failures++;
                $display("FAIL mid_after_%0d got=%b exp=0001", i, {busy, alu_start, rsp_valid, cmd_ready});
            end
            tick();
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_a      = 8'h00;
        cmd_b      = 8'h00;
        cmd_op     = 3'b000;
        alu_done   = 1'b0;
        alu_result = 16'h0000;
        rsp_ready  = 1'b0;

        test_reset();
        test_add();
        test_back_to_back();
        test_noop_rst();
        test_backpressure();
`ifdef TINYALU_ISSUER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
